// File: rtl/array_scan_reader.sv
// array_scan_reader: steps a 4-bit code over the array VAL bus from 0 to
// LAST_CODE. For each code it waits SETTLE cycles and samples the
// synchronized LED responses. It then streams the code and the sample as
// three ready/valid beats.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               scan request, only honoured while idle
//   val                 code currently driven onto the VAL bus
//   led0..led3, led4/5  LED responses (asynchronous to clk)
//   out_valid/out_ready result handshake; out_data carries the beat
//   busy                high whenever a scan is in progress
//   done                one-cycle pulse after the final beat of a scan
module array_scan_reader #(
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned LAST_CODE = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] val,
  input  logic [3:0] led0,
  input  logic [3:0] led1,
  input  logic [3:0] led2,
  input  logic [3:0] led3,
  input  logic       led4,
  input  logic       led5,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CAP_W  = 18;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned VAL_W  = 4;
  localparam int unsigned BEAT_W = 2;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [VAL_W-1:0]  LAST_VAL    = VAL_W'(LAST_CODE);
  localparam logic [BEAT_W-1:0] FINAL_BEAT  = BEAT_W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_SEND
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CAP_W-1:0]   led_raw;
  logic [CAP_W-1:0]   sync1;
  logic [CAP_W-1:0]   sync2;
  logic [CAP_W-1:0]   cap;
  logic [CNT_W-1:0]   cnt;
  logic [BEAT_W-1:0]  beat;
  logic               xfer;
  logic               last_xfer;

  // Capture layout, MSB first: led0, led1, led2, led3, led4, led5
  assign led_raw = {led0, led1, led2, led3, led4, led5};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake decode
  always_comb begin
    state_next = state;
    xfer       = 1'b0;
    last_xfer  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_DRIVE;
        end
      end
      S_DRIVE: state_next = S_SETTLE;
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: state_next = S_SEND;
      S_SEND: begin
        xfer = out_ready;
        if (out_ready && (beat == FINAL_BEAT)) begin
          last_xfer  = 1'b1;
          state_next = (val == LAST_VAL) ? S_IDLE : S_DRIVE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      cap       <= '0;
      cnt       <= '0;
      beat      <= '0;
      val       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sync1     <= led_raw;
      sync2     <= sync1;
      out_valid <= (state_next == S_SEND);
      busy      <= (state_next != S_IDLE);
      done      <= last_xfer && (val == LAST_VAL);
      case (state)
        S_IDLE: begin
          if (start) begin
            val  <= '0;
            beat <= '0;
          end
        end
        S_DRIVE:  cnt <= '0;
        S_SETTLE: cnt <= cnt + CNT_W'(1);
        S_SAMPLE: begin
          // Beat0 is built straight from the synchronizer so it is ready
          // on the first SEND cycle; later beats come from the frozen capture.
          cap      <= sync2;
          out_data <= {val, sync2[17:14]};
          beat     <= '0;
        end
        S_SEND: begin
          if (xfer) begin
            beat <= beat + BEAT_W'(1);
            case (beat)
              BEAT_W'(0): out_data <= {cap[13:10], cap[9:6]};
              BEAT_W'(1): out_data <= {cap[5:2], 2'b00, cap[1:0]};
              default:    ;
            endcase
            if (last_xfer) begin
              beat <= '0;
              if (val != LAST_VAL) begin
                val <= val + VAL_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
